// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronizes and filters the raw lines, deframes
// 11-bit device frames and folds E0/F0/E1 prefixes into toggle-published key events.
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 86000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk_i,
  input  logic        ps2_data_i,
  output logic [10:0] ps2_key_o,
  output logic        frame_err_o,
  output logic        busy_o
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_BITS, S_CHECK} state_t;

  logic          r_clk_s1, r_clk_s2;
  logic          r_dat_s1, r_dat_s2;
  logic          r_clk_filt;
  logic [FW-1:0] r_filt_cnt;
  logic          r_fall;

  state_t        r_state;
  logic [3:0]    r_bit_cnt;
  logic [TW-1:0] r_to_cnt;
  logic [9:0]    r_shreg;
  logic          r_ext, r_rel;
  logic [2:0]    r_skip;

  logic [7:0]    w_byte;
  logic          w_par_ok;
  logic          w_stop_ok;
  logic          w_ignore;

  // Stage 0: two-flop synchronizers; idle level of both lines is high
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk_i;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data_i;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Stage 1: filtered clock follows only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_clk_filt <= 1'b1;
      r_filt_cnt <= '0;
      r_fall     <= 1'b0;
    end else begin
      r_fall <= 1'b0;
      if (r_clk_s2 == r_clk_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FILT_LAST) begin
        r_clk_filt <= r_clk_s2;
        r_filt_cnt <= '0;
        r_fall     <= ~r_clk_s2;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  // Stage 2: LSB-first shift; after ten edges [7:0]=data, [8]=parity, [9]=stop
  always_ff @(posedge clk_sys) begin
    if (r_state == S_BITS && r_fall) begin
      r_shreg <= {r_dat_s2, r_shreg[9:1]};
    end
  end

  assign w_byte    = r_shreg[7:0];
  assign w_par_ok  = ^r_shreg[8:0];
  assign w_stop_ok = r_shreg[9];
  assign w_ignore  = (w_byte inside {8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF});

  // Stage 3: frame FSM, timeout and prefix folding with registered outputs
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= 4'd0;
      r_to_cnt    <= '0;
      r_ext       <= 1'b0;
      r_rel       <= 1'b0;
      r_skip      <= 3'd0;
      ps2_key_o   <= 11'h000;
      frame_err_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_fall) begin
            if (!r_dat_s2) begin
              r_state   <= S_BITS;
              r_bit_cnt <= 4'd0;
              r_to_cnt  <= '0;
              busy_o    <= 1'b1;
            end else begin
              frame_err_o <= 1'b1;
              r_ext       <= 1'b0;
              r_rel       <= 1'b0;
              r_skip      <= 3'd0;
            end
          end
        end
        S_BITS: begin
          // An edge landing on the timeout cycle still counts as a valid bit
          if (r_fall) begin
            r_to_cnt  <= '0;
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd9) begin
              r_state <= S_CHECK;
            end
          end else if (r_to_cnt == TO_LAST) begin
            r_state     <= S_IDLE;
            busy_o      <= 1'b0;
            frame_err_o <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          r_state <= S_IDLE;
          busy_o  <= 1'b0;
          if (w_stop_ok && w_par_ok) begin
            if (r_skip != 3'd0) begin
              r_skip <= r_skip - 3'd1;
            end else if (w_byte == 8'hE1) begin
              r_skip <= 3'd7;
            end else if (w_byte == 8'hE0) begin
              r_ext <= 1'b1;
            end else if (w_byte == 8'hF0) begin
              r_rel <= 1'b1;
            end else if (!(w_ignore && !r_ext && !r_rel)) begin
              ps2_key_o <= {~ps2_key_o[10], ~r_rel, r_ext, w_byte};
              r_ext     <= 1'b0;
              r_rel     <= 1'b0;
            end
          end else begin
            // Drop any pending prefix so it cannot attach to the next code
            frame_err_o <= 1'b1;
            r_ext       <= 1'b0;
            r_rel       <= 1'b0;
            r_skip      <= 3'd0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: frame-level event model with an ordered expectation
// queue, checked every cycle, plus directed literal checks and random frames.
module tb_ps2_key_decoder;
  localparam int FL   = 4;
  localparam int TO   = 400;
  localparam int HALF = 40;

  logic        clk_sys  = 1'b0;
  logic        reset    = 1'b1;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key_o;
  logic        frame_err_o;
  logic        busy_o;

  always #5 clk_sys = ~clk_sys;

  ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ps2_clk_i   (ps2_clk),
    .ps2_data_i  (ps2_data),
    .ps2_key_o   (ps2_key_o),
    .frame_err_o (frame_err_o),
    .busy_o      (busy_o)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Expected outputs in order: bit 11 set means an error pulse, else a key word
  logic [11:0] exp_q[$];
  logic [11:0] e;
  logic [10:0] last_key = 11'h000;

  bit m_tog = 1'b0;
  bit m_ext = 1'b0;
  bit m_rel = 1'b0;
  int m_skip = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // Keyboard-level meaning of one received byte
  task automatic model_frame(input logic [7:0] b, input bit ok);
    if (!ok) begin
      exp_q.push_back(12'h800);
      m_ext = 0; m_rel = 0; m_skip = 0;
    end else if (m_skip != 0) begin
      m_skip = m_skip - 1;
    end else if (b == 8'hE1) begin
      m_skip = 7;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_rel = 1;
    end else if (!m_ext && !m_rel && (b inside {8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF})) begin
      // discarded
    end else begin
      m_tog = ~m_tog;
      exp_q.push_back({1'b0, m_tog, ~m_rel, m_ext, b});
      m_ext = 0; m_rel = 0;
    end
  endtask

  always @(negedge clk_sys) begin
    if (reset) begin
      last_key = 11'h000;
    end else begin
      if (ps2_key_o !== last_key) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", 32'(ps2_key_o), 32'(last_key));
        end else begin
          e = exp_q.pop_front();
          check("event", 32'(ps2_key_o), 32'(e));
        end
        last_key = ps2_key_o;
      end
      if (frame_err_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_err", 32'(frame_err_o), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("err_pulse", 32'h800, 32'(e));
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic pulse_bit(input logic d);
    ps2_data = d;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    model_frame(b, !(bad_par || bad_stop));
    pulse_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      pulse_bit(b[i]);
      if (i == 3) check("busy_mid_frame", 32'(busy_o), 32'd1);
    end
    pulse_bit((~^b) ^ bad_par);
    pulse_bit(~bad_stop);
    ps2_data = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic settle(input string name);
    wait_cyc(20);
    check(name, 32'(exp_q.size()), 32'd0);
    check("busy_idle", 32'(busy_o), 32'd0);
  endtask

  initial begin
    logic [7:0] pause_seq [9];
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h16};

    wait_cyc(5);
    check("reset_key", 32'(ps2_key_o), 32'h000);
    check("reset_err", 32'(frame_err_o), 32'd0);
    check("reset_busy", 32'(busy_o), 32'd0);
    reset = 1'b0;
    wait_cyc(5);

    send_frame(8'h1C, 0, 0); settle("make1_drain");
    check("make1_key", 32'(ps2_key_o), 32'h61C);
    send_frame(8'h1C, 0, 0); settle("make2_drain");
    check("make2_key", 32'(ps2_key_o), 32'h21C);

    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0); settle("ext_rel_drain");
    check("ext_rel_key", 32'(ps2_key_o), 32'h575);

    send_frame(8'hF0, 1, 0); settle("parity_drain");
    send_frame(8'h12, 0, 0); settle("after_parity_drain");
    check("after_parity_key", 32'(ps2_key_o), 32'h212);

    exp_q.push_back(12'h800);
    pulse_bit(1'b0);
    for (int i = 0; i < 4; i++) pulse_bit(1'b1);
    check("busy_before_timeout", 32'(busy_o), 32'd1);
    wait_cyc(TO + 50);
    settle("timeout_drain");
    send_frame(8'h29, 0, 0); settle("after_timeout_drain");
    check("after_timeout_key", 32'(ps2_key_o), 32'h629);

    foreach (pause_seq[i]) send_frame(pause_seq[i], 0, 0);
    settle("pause_drain");
    check("pause_key", 32'(ps2_key_o), 32'h216);

    ps2_clk = 1'b0;
    wait_cyc(FL - 1);
    ps2_clk = 1'b1;
    wait_cyc(30);
    settle("glitch_drain");

    send_frame(8'hAA, 0, 0); settle("bat_drain");
    check("bat_key", 32'(ps2_key_o), 32'h216);

    model_frame(8'h00, 0);
    pulse_bit(1'b1);
    ps2_data = 1'b1;
    settle("start_err_drain");

    pulse_bit(1'b0); pulse_bit(1'b1); pulse_bit(1'b0);
    check("busy_before_reset", 32'(busy_o), 32'd1);
    reset = 1'b1;
    wait_cyc(2);
    check("midreset_key", 32'(ps2_key_o), 32'h000);
    check("midreset_err", 32'(frame_err_o), 32'd0);
    check("midreset_busy", 32'(busy_o), 32'd0);
    reset = 1'b0;
    m_tog = 0; m_ext = 0; m_rel = 0; m_skip = 0;
    exp_q.delete();
    ps2_data = 1'b1;
    wait_cyc(10);
    send_frame(8'h1C, 0, 0); settle("post_reset_drain");
    check("post_reset_key", 32'(ps2_key_o), 32'h61C);

    for (int n = 0; n < 35; n++) begin
      int r;
      logic [7:0] b;
      bit bp, bs;
      r = $urandom_range(0, 99);
      if (r < 10)      b = 8'hE0;
      else if (r < 20) b = 8'hF0;
      else if (r < 24) b = 8'hE1;
      else if (r < 28) b = 8'hAA;
      else             b = 8'($urandom_range(0, 255));
      bp = ($urandom_range(0, 9) == 0);
      bs = ($urandom_range(0, 19) == 0);
      send_frame(b, bp, bs);
      settle("random_drain");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
